fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_pkg.sv | 20 ++
 rtl/fb_clear_fsm.sv | 65 ++++++
 rtl/fb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, pixel/address types and clear-engine state encoding
package fb_pkg;
  localparam int FB_H_RES  = 320;
  localparam int FB_V_RES  = 240;
  localparam int FB_WORDS  = FB_H_RES * FB_V_RES;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 12;

  typedef logic [FB_DATA_W-1:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_t;

  function automatic logic addr_oor(input logic [31:0] addr, input int words);
    return addr >= 32'(words);
  endfunction
endpackage

// File: rtl/fb_clear_fsm.sv
// rtl/fb_clear_fsm.sv - framebuffer clear engine: fills words 0..WORDS-1 with a latched colour, one per cycle
module fb_clear_fsm import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int WORDS  = FB_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_din
);
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    clr_busy = 1'b0;
    clr_we   = 1'b0;
    clr_addr = '0;
    clr_din  = '0;
    last     = (32'(cnt_q) == 32'(WORDS - 1));
    case (state_q)
      CLR_IDLE: begin
        // Colour is captured at start so the caller need not hold it.
        if (clr_start) begin
          state_d = CLR_ACTIVE;
          cnt_d   = '0;
          color_d = clr_color;
        end
      end
      CLR_ACTIVE: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        clr_addr = cnt_q;
        clr_din  = color_q;
        if (last) begin
          state_d = CLR_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - read-priority framebuffer BRAM port arbiter with write anti-starvation
// Optional clear engine enabled by defining FB_ARB_CLEAR_EN.
module fb_port_arbiter import fb_pkg::*; #(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FB_WORDS   = fb_pkg::FB_WORDS,
  parameter int RAM_LAT    = 1,
  parameter int MAX_RD_RUN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef FB_ARB_CLEAR_EN
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
`endif
  output logic              err_oor
);
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [RAM_LAT-1:0] vld_q, vld_d;
  logic [RAM_LAT-1:0] oor_pipe_q, oor_pipe_d;
  logic               err_q, err_d;
  logic               rd_oor, wr_oor, starve, busy;
  logic               clr_we;
  logic [ADDR_W-1:0]  clr_addr;
  logic [DATA_W-1:0]  clr_din;

`ifdef FB_ARB_CLEAR_EN
  fb_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WORDS  (FB_WORDS)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_din   (clr_din)
  );
  assign clr_busy = busy && !rst;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign clr_din  = '0;
`endif

  always_comb begin
    rd_oor   = addr_oor(32'(rd_addr), FB_WORDS);
    wr_oor   = addr_oor(32'(wr_addr), FB_WORDS);
    // A write that has waited out MAX_RD_RUN read grants takes the next slot.
    starve   = wr_req && (run_cnt_q == RUN_W'(MAX_RD_RUN));
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst && !busy) begin
      if (rd_req && !starve) begin
        rd_gnt = 1'b1;
      end else if (wr_req) begin
        wr_gnt = 1'b1;
      end
    end
    if (!rst) begin
      if (busy) begin
        ram_we   = clr_we;
        ram_addr = clr_addr;
        ram_din  = clr_din;
      end else if (rd_gnt && !rd_oor) begin
        ram_addr = rd_addr;
      end else if (wr_gnt && !wr_oor) begin
        ram_we   = 1'b1;
        ram_addr = wr_addr;
        ram_din  = wr_data;
      end
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!wr_req || wr_gnt) begin
      run_cnt_d = '0;
    end else if (rd_gnt) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
    vld_d      = (vld_q << 1) | RAM_LAT'(rd_gnt);
    oor_pipe_d = (oor_pipe_q << 1) | RAM_LAT'(rd_gnt && rd_oor);
    err_d      = (rd_gnt && rd_oor) || (wr_gnt && wr_oor);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q  <= '0;
      vld_q      <= '0;
      oor_pipe_q <= '0;
      err_q      <= 1'b0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      vld_q      <= vld_d;
      oor_pipe_q <= oor_pipe_d;
      err_q      <= err_d;
    end
  end

  // Out-of-range reads still return a beat on schedule, but with zero data.
  assign rd_valid = !rst && vld_q[RAM_LAT-1];
  assign rd_data  = (rd_valid && !oor_pipe_q[RAM_LAT-1]) ? ram_dout : '0;
  assign err_oor  = !rst && err_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - self-checking bench for fb_port_arbiter; clear test built when FB_ARB_CLEAR_EN is defined
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int AW     = 17;
  localparam int DW     = 12;
  localparam int WORDS  = 76800;
  localparam int LAT    = 1;
  localparam int MAXRUN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_gnt, wr_gnt, rd_valid, ram_we, err_oor;
  logic [DW-1:0] rd_data, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy_w;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vcount  = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(WORDS), .RAM_LAT(LAT), .MAX_RD_RUN(MAXRUN)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
`ifdef FB_ARB_CLEAR_EN
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy_w),
`endif
    .err_oor(err_oor)
  );

`ifndef FB_ARB_CLEAR_EN
  assign clr_busy_w = 1'b0;
`endif

  // Preload image: filled circle of radius 100 centred at (160,120), address-derived background.
  function automatic pixel_t circle_px(input int a);
    int x, y;
    x = a % FB_H_RES - 160;
    y = a / FB_H_RES - 120;
    if (x * x + y * y <= 10000) return 12'hF00;
    return pixel_t'(a) ^ 12'h5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-port BRAM, read-first, RAM_LAT=1.
  initial begin
    logic [DW-1:0] ram [WORDS];
    for (int i = 0; i < WORDS; i++) ram[i] = circle_px(i);
    ram_dout = '0;
    forever begin
      @(posedge clk);
      if (int'(ram_addr) < WORDS) begin
        ram_dout <= ram[int'(ram_addr)];
        if (ram_we) ram[int'(ram_addr)] <= ram_din;
      end else begin
        ram_dout <= '0;
      end
    end
  end

  always @(negedge clk) if (rd_valid) vcount++;

  // Behavioural model: priority rules, a run counter, a shadow image and a queue of due read beats.
  typedef struct { int due; logic [DW-1:0] data; } rd_pend_t;
  initial begin
    logic [DW-1:0] shadow [WORDS];
    rd_pend_t      pend[$];
    rd_pend_t      head;
    int            run, clr_left, clr_idx;
    logic [DW-1:0] clr_col;
    bit            err_next, rd_in, wr_in;
    logic          e_rg, e_wg, e_we, e_rv, e_err, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd;
    for (int i = 0; i < WORDS; i++) shadow[i] = circle_px(i);
    run = 0; clr_left = 0; clr_idx = 0; clr_col = '0; err_next = 0;
    forever begin
      @(negedge clk);
      cyc++;
      e_rg = 0; e_wg = 0; e_we = 0; e_rv = 0; e_err = 0; e_busy = 0;
      e_addr = '0; e_din = '0; e_rd = '0;
      rd_in = int'(rd_addr) < WORDS;
      wr_in = int'(wr_addr) < WORDS;
      if (rst) begin
        pend.delete();
        run = 0; err_next = 0; clr_left = 0;
      end else begin
        e_err = err_next;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          head = pend.pop_front();
          e_rv = 1; e_rd = head.data;
        end
        if (clr_left > 0) begin
          e_busy = 1; e_we = 1; e_addr = AW'(clr_idx); e_din = clr_col;
        end else begin
          if (rd_req && !(wr_req && run == MAXRUN)) e_rg = 1;
          else if (wr_req) e_wg = 1;
          if (e_rg && rd_in) e_addr = rd_addr;
          if (e_wg && wr_in) begin e_we = 1; e_addr = wr_addr; e_din = wr_data; end
        end
      end
      check("m_rd_gnt",   32'(rd_gnt),   32'(e_rg));
      check("m_wr_gnt",   32'(wr_gnt),   32'(e_wg));
      check("m_ram_we",   32'(ram_we),   32'(e_we));
      check("m_ram_addr", 32'(ram_addr), 32'(e_addr));
      check("m_ram_din",  32'(ram_din),  32'(e_din));
      check("m_rd_valid", 32'(rd_valid), 32'(e_rv));
      check("m_rd_data",  32'(rd_data),  32'(e_rd));
      check("m_err_oor",  32'(err_oor),  32'(e_err));
`ifdef FB_ARB_CLEAR_EN
      check("m_clr_busy", 32'(clr_busy_w), 32'(e_busy));
`endif
      if (!rst) begin
        err_next = (e_rg && !rd_in) || (e_wg && !wr_in);
        if (e_rg) pend.push_back('{due: cyc + LAT, data: rd_in ? shadow[int'(rd_addr)] : '0});
        if (e_we) shadow[int'(e_addr)] = e_din;
        if (!wr_req || e_wg) run = 0;
        else if (e_rg) run++;
        if (clr_left > 0) begin
          clr_idx++; clr_left--;
        end else if (clr_start) begin
          clr_left = WORDS; clr_idx = 0; clr_col = clr_color;
        end
      end
    end
  end

  typedef struct { bit r; int ra; bit w; int wa; int wd; } vec_t;

  task automatic starve_run(input string name);
    int gcyc;
    gcyc = 0;
    rd_req = 1; wr_req = 1;
    for (int k = 1; k <= 20; k++) begin
      rd_addr = AW'(300 + k);
      @(negedge clk);
      if (wr_gnt) begin gcyc = k; break; end
      step();
    end
    check(name, 32'(gcyc), 32'd9);
    step();
    wr_req = 0;
  endtask

  initial begin
    int v0, bcount, gseen;
    vec_t vecs[8];
    vecs = '{
      '{r:0, ra:0,     w:1, wa:1000,  wd:12'h111},
      '{r:1, ra:1000,  w:1, wa:1001,  wd:12'h222},
      '{r:0, ra:0,     w:1, wa:1001,  wd:12'h222},
      '{r:1, ra:1001,  w:0, wa:0,     wd:0},
      '{r:1, ra:90000, w:1, wa:2,     wd:12'h333},
      '{r:0, ra:0,     w:1, wa:99999, wd:12'h444},
      '{r:0, ra:0,     w:0, wa:0,     wd:0},
      '{r:1, ra:38560, w:0, wa:0,     wd:0}
    };
    rst = 1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    clr_start = 0; clr_color = '0;
    #1;
    repeat (3) step();
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    step();
    rst = 0;

    // Continuous reads of 0..255.
    v0 = vcount;
    rd_req = 1;
    for (int i = 0; i < 256; i++) begin
      rd_addr = AW'(i);
      if (i == 201) begin
        @(negedge clk);
        check("t030_data_200", 32'(rd_data), 32'h56D);
      end
      step();
    end
    rd_req = 0; rd_addr = '0;
    step(); step();
    check("t030_valid_count", 32'(vcount - v0), 32'd256);

    // Write starved by reads gets the 9th slot.
    wr_addr = AW'(5); wr_data = 12'hABC;
    starve_run("t031_wr_gnt_cycle");
    rd_req = 1; rd_addr = AW'(5);
    step();
    rd_req = 0;
    @(negedge clk);
    check("t031_readback_valid", 32'(rd_valid), 32'd1);
    check("t031_readback_data", 32'(rd_data), 32'hABC);
    step();

    // Out-of-range write.
    wr_req = 1; wr_addr = AW'(76800); wr_data = 12'hFFF;
    @(negedge clk);
    check("t032_wr_gnt", 32'(wr_gnt), 32'd1);
    check("t032_ram_we", 32'(ram_we), 32'd0);
    step();
    wr_req = 0;
    @(negedge clk);
    check("t032_err_oor", 32'(err_oor), 32'd1);
    step();
    rd_req = 1; rd_addr = AW'(76799);
    step();
    rd_req = 0;
    @(negedge clk);
    check("t032_last_word", 32'(rd_data), 32'hE5A);
    step();

    // Out-of-range read.
    rd_req = 1; rd_addr = 17'h1FFFF;
    @(negedge clk);
    check("t033_rd_gnt", 32'(rd_gnt), 32'd1);
    check("t033_ram_addr", 32'(ram_addr), 32'd0);
    step();
    rd_req = 0;
    @(negedge clk);
    check("t033_rd_valid", 32'(rd_valid), 32'd1);
    check("t033_rd_data", 32'(rd_data), 32'd0);
    check("t033_err_oor", 32'(err_oor), 32'd1);
    step();

    // Reset one cycle after a read grant, mid read-run.
    rd_req = 1; wr_req = 1; rd_addr = AW'(40); wr_addr = AW'(7); wr_data = 12'h123;
    repeat (5) step();
    rst = 1; rd_req = 0; wr_req = 0;
    @(negedge clk);
    check("t034_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t034_rst_ram_addr", 32'(ram_addr), 32'd0);
    step();
    rst = 0;
    @(negedge clk);
    check("t034_no_late_valid", 32'(rd_valid), 32'd0);
    step();
    starve_run("t034_run_restart");
    rd_req = 0;
    step();

    // Mixed directed vectors, one cycle each with an idle gap.
    foreach (vecs[i]) begin
      rd_req = vecs[i].r; rd_addr = AW'(vecs[i].ra);
      wr_req = vecs[i].w; wr_addr = AW'(vecs[i].wa); wr_data = DW'(vecs[i].wd);
      step();
      rd_req = 0; wr_req = 0;
      step();
    end

`ifdef FB_ARB_CLEAR_EN
    clr_color = 12'h0F0; clr_start = 1;
    step();
    clr_start = 0; clr_color = 12'h00F; rd_req = 1; rd_addr = AW'(3);
    bcount = 0; gseen = 0;
    for (int k = 0; k < 80000; k++) begin
      @(negedge clk);
      if (!clr_busy_w) break;
      bcount++;
      if (rd_gnt || wr_gnt) gseen++;
      clr_start = (k == 100);
      step();
    end
    check("t035_busy_cycles", 32'(bcount), 32'd76800);
    check("t035_no_grants", 32'(gseen), 32'd0);
    step();
    rd_addr = AW'(0);
    step();
    rd_addr = AW'(76799);
    @(negedge clk);
    check("t035_word0", 32'(rd_data), 32'h0F0);
    step();
    rd_req = 0;
    @(negedge clk);
    check("t035_word_last", 32'(rd_data), 32'h0F0);
    step();
`else
    bcount = 0; gseen = 0;
    check("cfg_no_clear_busy", 32'(clr_busy_w) + 32'(bcount) + 32'(gseen), 32'd0);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
